// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding and byte width for the UART transmit scheduler.
package uart_sched_pkg;
    localparam int UART_BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter granting the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the closest valid index to ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            gnt = req[idx] ? N'(1) << idx : gnt;
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one uart_transmit between NUM_REQ byte streams with round-robin and packet locking.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 100_000
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]             req_last_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    output logic                           uart_trigger_out,
    output logic [UART_BYTE_W-1:0]         uart_data_out,
    input  logic                           uart_busy_in,
    output logic [NUM_REQ-1:0]             grant_out,
    output logic                           locked_out,
    output logic                           timeout_pulse_out
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    sched_state_t           state;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          win_idx;
    logic [CW-1:0]          cnt;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [UART_BYTE_W-1:0] win_data;
    logic                   accept;
    logic                   win_last;
    logic                   owner_idle;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req(req_valid_in),
        .ptr(ptr),
        .gnt(arb_gnt)
    );

    // The previous grant doubles as the lock owner.
    assign req_ready_out = (state == IDLE && !uart_busy_in) ?
                           (locked_out ? grant_out & req_valid_in : arb_gnt) : '0;
    assign accept        = |req_ready_out;
    assign win_last      = |(req_ready_out & req_last_in);
    assign owner_idle    = state == IDLE && locked_out && !(|(grant_out & req_valid_in));

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx  = req_ready_out[i] ? PW'(i) : win_idx;
            win_data = req_ready_out[i] ? req_data_in[UART_BYTE_W*i +: UART_BYTE_W] : win_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            ptr               <= '0;
            cnt               <= '0;
            grant_out         <= '0;
            locked_out        <= 1'b0;
            uart_data_out     <= '0;
            uart_trigger_out  <= 1'b0;
            timeout_pulse_out <= 1'b0;
        end else begin
            uart_trigger_out  <= 1'b0;
            timeout_pulse_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state            <= LAUNCH;
                        uart_trigger_out <= 1'b1;
                        uart_data_out    <= win_data;
                        grant_out        <= req_ready_out;
                        locked_out       <= !win_last;
                        ptr              <= win_idx == PW'(NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                        cnt              <= '0;
                    end else if (owner_idle) begin
                        locked_out        <= cnt != CW'(LOCK_TIMEOUT - 1);
                        timeout_pulse_out <= cnt == CW'(LOCK_TIMEOUT - 1);
                        cnt               <= cnt == CW'(LOCK_TIMEOUT - 1) ? '0 : cnt + 1'b1;
                    end
                end
                LAUNCH:    state <= WAIT_BUSY;
                WAIT_BUSY: state <= uart_busy_in ? WAIT_DONE : WAIT_BUSY;
                WAIT_DONE: state <= uart_busy_in ? WAIT_DONE : IDLE;
                default:   state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: bench with a behavioural uart_transmit busy model and a queue-level scheduling model.
module tb_uart_tx_scheduler;
    localparam int N        = 4;
    localparam int TMO      = 50;
    localparam int BUSY_CYC = 10 * 16;
    localparam logic [N-1:0] G2 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [7:0]   D2 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    localparam logic [N-1:0] G3 [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
    localparam logic [7:0]   D3 [4] = '{8'h11, 8'h22, 8'h33, 8'h77};
    localparam logic         L3 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    typedef struct { logic [N-1:0] grant; logic [7:0] data; logic locked; int cyc; } trig_t;
    typedef struct { int req; logic [7:0] data; logic last; logic [N-1:0] grant; logic locked; } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   valid = '0;
    logic [N-1:0]   last = '0;
    logic [N*8-1:0] data = '0;
    logic [N-1:0]   ready, grant, hs;
    logic [7:0]     udata;
    logic           trigger, locked, pulse;
    logic           ubusy = 1'b0, force_busy = 1'b0, pend = 1'b0, prev_acc = 1'b0, bad;
    int             n_tests = 0, n_fail = 0, cyc = 0, rem = 0;
    int             k, n, base, rel, total, len, np;
    logic [8:0]     byte_q [N][$];
    logic [8:0]     mdl_q [N][$];
    trig_t          trig_log [$];
    trig_t          exp_q [$];
    vec_t           vec [6];

    uart_tx_scheduler #(.NUM_REQ(N), .LOCK_TIMEOUT(TMO)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(valid), .req_data_in(data),
        .req_last_in(last), .req_ready_out(ready), .uart_trigger_out(trigger),
        .uart_data_out(udata), .uart_busy_in(ubusy | force_busy), .grant_out(grant),
        .locked_out(locked), .timeout_pulse_out(pulse)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // uart_transmit stand-in: busy rises the cycle after the trigger and lasts one 10-bit frame.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ubusy = 1'b0; rem = 0; pend = 1'b0;
        end else begin
            if (rem > 0) begin
                rem--;
                if (rem == 0) ubusy = 1'b0;
            end else if (pend) begin
                ubusy = 1'b1; rem = BUSY_CYC; pend = 1'b0;
            end
            if (trigger) pend = 1'b1;
        end
    end

    // Producers hold valid while their queue has bytes and pop on a handshake.
    initial forever begin
        @(negedge clk);
        hs = ready & valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rst_n && hs[i] && byte_q[i].size() > 0) void'(byte_q[i].pop_front());
            valid[i] = byte_q[i].size() > 0;
            {last[i], data[8*i +: 8]} = valid[i] ? byte_q[i][0] : 9'h0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (trigger) begin
            check("trig_latency", 32'(prev_acc), 32'd1);
            trig_log.push_back('{grant, udata, locked, cyc});
        end
        if (|(ready & valid)) check("ready_onehot", 32'($onehot(ready)), 32'd1);
        prev_acc = rst_n && |(ready & valid);
    end

    task automatic tick(int c = 1);
        repeat (c) @(negedge clk);
    endtask

    task automatic push(int r, logic [7:0] d, logic l);
        byte_q[r].push_back({l, d});
        mdl_q[r].push_back({l, d});
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            byte_q[i].delete();
            mdl_q[i].delete();
        end
        valid = '0; last = '0; data = '0;
    endtask

    task automatic check_zero(string name);
        check(name, 32'({ready, trigger, udata, grant, locked, pulse}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        clear_inputs();
        tick(3);
        rst_n = 1'b1;
        trig_log.delete();
    endtask

    task automatic wait_trigs(int cnt, int bound);
        int w = 0;
        while (trig_log.size() < cnt && w < bound) begin
            tick();
            w++;
        end
        if (trig_log.size() < cnt) check("trigger_wait", 32'(trig_log.size()), 32'(cnt));
    endtask

    task automatic settle();
        int quiet = 0, w = 0;
        while (quiet < 4 && w < 4 * BUSY_CYC) begin
            tick();
            w++;
            quiet = (!ubusy && !trigger && !(|valid)) ? quiet + 1 : 0;
        end
        if (quiet < 4) check("settle_timeout", 32'(quiet), 32'd4);
    endtask

    // Transaction-level expectation: owner keeps the UART until last=1, else nearest non-empty queue from ptr.
    task automatic build_expected();
        int ptr_m = 0, owner = -1, w = 0;
        logic [8:0] e;
        exp_q.delete();
        while (mdl_q[0].size() + mdl_q[1].size() + mdl_q[2].size() + mdl_q[3].size() > 0) begin
            if (owner >= 0) w = owner;
            else begin
                for (int j = 0; j < N; j++) begin
                    if (mdl_q[(ptr_m + j) % N].size() > 0) begin
                        w = (ptr_m + j) % N;
                        break;
                    end
                end
            end
            e = mdl_q[w].pop_front();
            exp_q.push_back('{N'(1) << w, e[7:0], !e[8], 0});
            ptr_m = (w + 1) % N;
            owner = e[8] ? -1 : w;
        end
    endtask

    initial begin
        vec[0] = '{0, 8'hA5, 1'b1, 4'b0001, 1'b0};
        vec[1] = '{2, 8'h3C, 1'b1, 4'b0100, 1'b0};
        vec[2] = '{1, 8'h11, 1'b0, 4'b0010, 1'b1};
        vec[3] = '{1, 8'h22, 1'b0, 4'b0010, 1'b1};
        vec[4] = '{1, 8'h33, 1'b1, 4'b0010, 1'b0};
        vec[5] = '{3, 8'hFF, 1'b1, 4'b1000, 1'b0};

        #2 rst_n = 1'b0;
        #1 check_zero("reset_state");
        tick(3);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            n = trig_log.size();
            push(vec[i].req, vec[i].data, vec[i].last);
            wait_trigs(n + 1, 20);
            if (trig_log.size() > n) begin
                check("vec_data", 32'(trig_log[n].data), 32'(vec[i].data));
                check("vec_grant", 32'(trig_log[n].grant), 32'(vec[i].grant));
                check("vec_locked", 32'(trig_log[n].locked), 32'(vec[i].locked));
            end
            settle();
            check("vec_data_hold", 32'(udata), 32'(vec[i].data));
        end

        do_reset();
        push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1);
        push(3, 8'h13, 1'b1); push(0, 8'h20, 1'b1);
        wait_trigs(5, 5 * (BUSY_CYC + 10));
        for (int i = 0; i < 5; i++) begin
            if (i < trig_log.size()) begin
                check("rr_grant", 32'(trig_log[i].grant), 32'(G2[i]));
                check("rr_data", 32'(trig_log[i].data), 32'(D2[i]));
                if (i > 0) check("rr_frame_spacing",
                                 32'(trig_log[i].cyc - trig_log[i-1].cyc > BUSY_CYC), 32'd1);
            end
        end
        settle();
        check("rr_trigger_count", 32'(trig_log.size()), 32'd5);

        do_reset();
        push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1); push(2, 8'h77, 1'b1);
        wait_trigs(4, 4 * (BUSY_CYC + 10));
        for (int i = 0; i < 4; i++) begin
            if (i < trig_log.size()) begin
                check("pkt_grant", 32'(trig_log[i].grant), 32'(G3[i]));
                check("pkt_data", 32'(trig_log[i].data), 32'(D3[i]));
                check("pkt_locked", 32'(trig_log[i].locked), 32'(L3[i]));
            end
        end
        settle();

        do_reset();
        push(3, 8'h3C, 1'b0);
        wait_trigs(1, 20);
        k = 0;
        while (!ubusy && k < 20) begin tick(); k++; end
        k = 0;
        while (ubusy && k < BUSY_CYC + 20) begin tick(); k++; end
        check("tmo_busy_fall", 32'(ubusy), 32'd0);
        base = cyc;
        push(0, 8'h5A, 1'b1);
        k = 0; bad = 1'b0;
        while (!pulse && k < TMO + 20) begin
            tick(); k++;
            bad = bad | (!pulse && |ready);
        end
        check("tmo_locked_no_ready", 32'(bad), 32'd0);
        check("tmo_pulse_cycle", 32'(cyc - base), 32'(TMO + 1));
        check("tmo_unlocked", 32'(locked), 32'd0);
        tick();
        check("tmo_pulse_width", 32'(pulse), 32'd0);
        check("tmo_regrant", 32'({grant, trigger, udata}), 32'({4'b0001, 1'b1, 8'h5A}));
        settle();

        do_reset();
        push(0, 8'h42, 1'b1);
        k = 0;
        while (!trigger && k < 20) begin tick(); k++; end
        check("rst_launch_seen", 32'(trigger), 32'd1);
        #2 rst_n = 1'b0;
        clear_inputs();
        #1 check_zero("rst_at_launch");
        tick(3);
        rst_n = 1'b1;
        n = trig_log.size();
        tick(300);
        check("rst_launch_no_retrigger", 32'(trig_log.size()), 32'(n));
        push(1, 8'h43, 1'b1);
        wait_trigs(n + 1, 20);
        k = 0;
        while (!ubusy && k < 20) begin tick(); k++; end
        tick(2);
        check("rst_busy_high", 32'(ubusy), 32'd1);
        #2 rst_n = 1'b0;
        clear_inputs();
        #1 check_zero("rst_in_wait_done");
        tick(3);
        rst_n = 1'b1;
        n = trig_log.size();
        tick(50);
        check("rst_done_no_retrigger", 32'(trig_log.size()), 32'(n));
        settle();

        do_reset();
        force_busy = 1'b1;
        push(0, 8'h66, 1'b1);
        bad = 1'b0;
        repeat (20) begin tick(); bad = bad | (|ready); end
        check("busy_no_ready", 32'(bad), 32'd0);
        check("busy_no_trigger", 32'(trig_log.size()), 32'd0);
        @(posedge clk);
        #1 force_busy = 1'b0;
        rel = cyc;
        #1 check("busy_release_ready", 32'(ready), 32'(4'b0001));
        wait_trigs(1, 5);
        if (trig_log.size() > 0) begin
            check("busy_release_data", 32'(trig_log[0].data), 32'h66);
            check("busy_release_latency", 32'(trig_log[0].cyc - rel), 32'd1);
        end
        settle();

        for (int r = 0; r < 2; r++) begin
            do_reset();
            total = 0;
            for (int i = 0; i < N; i++) begin
                np = $urandom_range(1, 3);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        push(i, 8'($urandom), b == len - 1);
                        total++;
                    end
                end
            end
            build_expected();
            wait_trigs(total, total * (BUSY_CYC + 10) + 100);
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i < trig_log.size()) begin
                    check("rnd_grant", 32'(trig_log[i].grant), 32'(exp_q[i].grant));
                    check("rnd_data", 32'(trig_log[i].data), 32'(exp_q[i].data));
                    check("rnd_locked", 32'(trig_log[i].locked), 32'(exp_q[i].locked));
                end
            end
            settle();
            check("rnd_trigger_count", 32'(trig_log.size()), 32'(total));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
